// File: rtl/s3g_tx_if.sv
// s3g_tx_if: payload-buffer write port, send request and dual-UART byte handshake
interface s3g_tx_if;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       send;
    logic [7:0] send_len;
    logic       send_dst;
    logic [7:0] tx_data;
    logic       tx1_start;
    logic       tx1_busy;
    logic       tx2_start;
    logic       tx2_busy;
    logic       busy;
    logic       packet_sent;
    logic       send_reject;

    modport master (
        output wr_en, wr_addr, wr_data, send, send_len, send_dst, tx1_busy, tx2_busy,
        input  tx_data, tx1_start, tx2_start, busy, packet_sent, send_reject
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, send, send_len, send_dst, tx1_busy, tx2_busy,
        output tx_data, tx1_start, tx2_start, busy, packet_sent, send_reject
    );
endinterface

// File: rtl/s3g_tx.sv
// s3g_tx: frames buffered payload as D5,len,data,crc8-maxim and feeds it byte-wise to one of two UARTs
module s3g_tx (
    input logic    clk,
    input logic    rst,
    s3g_tx_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_LEN, S_DATA, S_CRC} state_t;

    state_t     state_q, state_d;
    logic [7:0] mem [256];
    logic [7:0] rd_q;
    logic [7:0] len_q, len_d, addr_q, addr_d, crc_q, crc_d, tx_data_q, tx_data_d, byte_sel;
    logic       dst_q, dst_d, start_q, guard_q, sent_q, sent_d, reject_q, reject_d;
    logic       sel_busy, issue, last;

    function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] b);
        logic [7:0] r;
        r = c ^ b;
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 8'h8C) : (r >> 1);
        return r;
    endfunction

    assign sel_busy = dst_q ? bus.tx2_busy : bus.tx1_busy;
    // start_q blocks the cycle the UART has not yet raised busy; guard_q covers the buffer read latency
    assign issue    = (state_q inside {S_SYNC, S_LEN, S_DATA, S_CRC}) && !sel_busy && !start_q && !guard_q;
    assign last     = addr_q == len_q - 8'd1;
    assign byte_sel = state_q == S_SYNC ? 8'hD5 :
                      state_q == S_LEN  ? len_q :
                      state_q == S_DATA ? rd_q  : crc_q;

    assign bus.tx_data     = tx_data_q;
    assign bus.tx1_start   = start_q & ~dst_q;
    assign bus.tx2_start   = start_q & dst_q;
    assign bus.busy        = state_q != S_IDLE;
    assign bus.packet_sent = sent_q;
    assign bus.send_reject = reject_q;

    // payload buffer: writes in any state, including reset; registered read of the current address
    always_ff @(posedge clk) begin
        if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
        rd_q <= mem[addr_q];
    end

    // next-state and issue decisions
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        dst_d     = dst_q;
        addr_d    = addr_q;
        crc_d     = crc_q;
        sent_d    = 1'b0;
        reject_d  = 1'b0;
        tx_data_d = issue ? byte_sel : tx_data_q;
        case (state_q)
            S_IDLE: if (bus.send) begin
                if (bus.send_len != 8'd0) begin
                    state_d = S_SYNC;
                    len_d   = bus.send_len;
                    dst_d   = bus.send_dst;
                    crc_d   = 8'h00;
                    addr_d  = 8'd0;
                end else begin
                    reject_d = 1'b1;
                end
            end
            S_SYNC: if (issue) state_d = S_LEN;
            S_LEN:  if (issue) state_d = S_DATA;
            S_DATA: if (issue) begin
                crc_d   = crc8(crc_q, rd_q);
                addr_d  = last ? addr_q : addr_q + 8'd1;
                state_d = last ? S_CRC : S_DATA;
            end
            S_CRC:  if (issue) begin
                state_d = S_IDLE;
                sent_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            len_q     <= 8'd0;
            dst_q     <= 1'b0;
            addr_q    <= 8'd0;
            crc_q     <= 8'h00;
            tx_data_q <= 8'h00;
            start_q   <= 1'b0;
            guard_q   <= 1'b0;
            sent_q    <= 1'b0;
            reject_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            dst_q     <= dst_d;
            addr_q    <= addr_d;
            crc_q     <= crc_d;
            tx_data_q <= tx_data_d;
            start_q   <= issue;
            guard_q   <= start_q;
            sent_q    <= sent_d;
            reject_q  <= reject_d;
        end
    end
endmodule

// File: tb/tb_s3g_tx.sv
// tb_s3g_tx: directed checks of framing, crc, port select, busy handshake, reject, ignore and reset abort
module tb_s3g_tx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    s3g_tx_if bus ();
    s3g_tx dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int tests = 0, failed = 0;
    int b1 = 0, b2 = 0, busy_len = 0;
    int n_sent = 0, n_rej = 0, viol = 0;
    logic [7:0] q1[$], q2[$], exp_q[$];
    int base1, base2, sent0, rej0, hold;

    assign bus.tx1_busy = b1 != 0;
    assign bus.tx2_busy = b2 != 0;

    // UART busy model: busy for busy_len cycles after each start it sees
    always @(posedge clk) begin
        if (bus.tx1_start) b1 <= busy_len; else if (b1 > 0) b1 <= b1 - 1;
        if (bus.tx2_start) b2 <= busy_len; else if (b2 > 0) b2 <= b2 - 1;
    end

    // byte/pulse monitor
    always @(negedge clk) begin
        if (bus.tx1_start) begin q1.push_back(bus.tx_data); if (bus.tx1_busy) viol++; end
        if (bus.tx2_start) begin q2.push_back(bus.tx_data); if (bus.tx2_busy) viol++; end
        if (bus.packet_sent) n_sent++;
        if (bus.send_reject) n_rej++;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic do_send(input logic [7:0] len, input logic dst);
        bus.send = 1'b1; bus.send_len = len; bus.send_dst = dst;
        @(negedge clk);
        bus.send = 1'b0;
    endtask

    task automatic wait_sent(input string tag, input int target, input int lim);
        int t = 0;
        while (n_sent < target && t < lim) begin @(negedge clk); t++; end
        chk({tag, "_done"}, int'(n_sent >= target), 1);
    endtask

    task automatic snap();
        base1 = q1.size(); base2 = q2.size(); sent0 = n_sent; rej0 = n_rej;
    endtask

    task automatic cmp_bytes(input string tag, input bit p);
        int n;
        logic [7:0] g;
        n = p ? q2.size() - base2 : q1.size() - base1;
        chk({tag, "_count"}, n, exp_q.size());
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            g = p ? q2[base2 + i] : q1[base1 + i];
            chk($sformatf("%s_byte%0d", tag, i), g, exp_q[i]);
        end
    endtask

    function automatic logic [7:0] ref_crc(input int n);
        logic [7:0] c, v;
        logic fb;
        c = 8'h00;
        for (int i = 0; i < n; i++) begin
            v = i[7:0];
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ v[b];
                c = {1'b0, c[7:1]} ^ (fb ? 8'h8C : 8'h00);
            end
        end
        return c;
    endfunction

    initial begin
        bus.wr_en = 1'b0; bus.wr_addr = 8'd0; bus.wr_data = 8'd0;
        bus.send = 1'b0; bus.send_len = 8'd0; bus.send_dst = 1'b0;
        tick(2);
        // buffer loaded while in reset; a send during reset must be dropped
        for (int i = 0; i < 9; i++) wr(i[7:0], 8'h31 + i[7:0]);
        bus.send = 1'b1; bus.send_len = 8'd5;
        @(negedge clk);
        bus.send = 1'b0;
        chk("rst_busy", bus.busy, 0);
        chk("rst_txdata", bus.tx_data, 8'h00);
        chk("rst_tx1_start", bus.tx1_start, 0);
        chk("rst_tx2_start", bus.tx2_start, 0);
        chk("rst_sent", bus.packet_sent, 0);
        chk("rst_reject", bus.send_reject, 0);
        rst = 1'b0;
        tick(3);
        chk("rst_send_dropped", bus.busy, 0);

        // check string on port 1
        snap(); busy_len = 0;
        do_send(8'd9, 1'b0);
        chk("t1_busy_up", bus.busy, 1);
        wait_sent("t1", sent0 + 1, 400);
        tick(5);
        exp_q = {8'hD5, 8'h09, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hA1};
        cmp_bytes("t1", 1'b0);
        chk("t1_tx2_none", q2.size() - base2, 0);
        chk("t1_sent_once", n_sent - sent0, 1);
        chk("t1_busy_down", bus.busy, 0);
        chk("t1_txdata_hold", bus.tx_data, 8'hA1);

        // single zero byte on port 2 with a slow UART
        wr(8'd0, 8'h00);
        snap(); busy_len = 10;
        do_send(8'd1, 1'b1);
        wait_sent("t2", sent0 + 1, 400);
        tick(15);
        exp_q = {8'hD5, 8'h01, 8'h00, 8'h00};
        cmp_bytes("t2", 1'b1);
        chk("t2_tx1_none", q1.size() - base1, 0);
        chk("t2_busy_respected", viol, 0);
        busy_len = 0;

        // zero-length request is refused
        snap();
        do_send(8'd0, 1'b0);
        chk("t3_reject_pulse", bus.send_reject, 1);
        chk("t3_busy", bus.busy, 0);
        tick(1);
        chk("t3_reject_once", bus.send_reject, 0);
        tick(5);
        chk("t3_reject_count", n_rej - rej0, 1);
        chk("t3_no_starts", (q1.size() - base1) + (q2.size() - base2), 0);

        // requests during a transfer are ignored
        wr(8'd0, 8'h31);
        snap();
        do_send(8'd9, 1'b0);
        tick(10);
        do_send(8'd0, 1'b0);
        tick(4);
        do_send(8'd5, 1'b1);
        wait_sent("t4", sent0 + 1, 400);
        tick(10);
        exp_q = {8'hD5, 8'h09, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hA1};
        cmp_bytes("t4", 1'b0);
        chk("t4_tx2_none", q2.size() - base2, 0);
        chk("t4_no_reject", n_rej - rej0, 0);
        chk("t4_sent_once", n_sent - sent0, 1);
        chk("t4_idle", bus.busy, 0);

        // reset after the third payload byte aborts the packet
        snap();
        do_send(8'd9, 1'b0);
        begin
            int t = 0;
            while (q1.size() - base1 < 5 && t < 200) begin @(negedge clk); t++; end
        end
        chk("t5_reached", q1.size() - base1, 5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_busy_cleared", bus.busy, 0);
        hold = q1.size() + q2.size();
        tick(20);
        chk("t5_no_more_starts", q1.size() + q2.size() - hold, 0);
        chk("t5_no_sent", n_sent - sent0, 0);
        wr(8'd0, 8'h00);
        wr(8'd1, 8'h01);
        snap();
        do_send(8'd2, 1'b0);
        wait_sent("t5b", sent0 + 1, 400);
        tick(5);
        exp_q = {8'hD5, 8'h02, 8'h00, 8'h01, 8'h5E};
        cmp_bytes("t5b", 1'b0);

        // maximum length, incrementing payload
        for (int i = 0; i < 255; i++) wr(i[7:0], i[7:0]);
        snap();
        do_send(8'd255, 1'b0);
        wait_sent("t6", sent0 + 1, 3000);
        tick(5);
        exp_q = {8'hD5, 8'hFF};
        for (int i = 0; i < 255; i++) exp_q.push_back(i[7:0]);
        exp_q.push_back(ref_crc(255));
        cmp_bytes("t6", 1'b0);
        chk("t6_addr_stop", dut.addr_q, 254);
        chk("t6_tx2_none", q2.size() - base2, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/s3g_tx.md
S3G_TX -- requirements
Module: s3g_tx

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all logic on rising edge.
REQ-002 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have port: wr_en  in  1  payload buffer write strobe.
REQ-004 SHALL have port: wr_addr  in  8  payload buffer write address.
REQ-005 SHALL have port: wr_data  in  8  payload buffer write data.
REQ-006 SHALL have port: send  in  1  one-cycle request to transmit a packet.
REQ-007 SHALL have port: send_len  in  8  payload length for the request (1..255).
REQ-008 SHALL have port: send_dst  in  1  destination port: 0 = port 1, 1 = port 2.
REQ-009 SHALL have port: tx_data  out  8  byte presented to both UART transmitters.
REQ-010 SHALL have port: tx1_start  out  1  byte start pulse to UART 1.
REQ-011 SHALL have port: tx1_busy  in  1  UART 1 shifting.
REQ-012 SHALL have port: tx2_start  out  1  byte start pulse to UART 2.
REQ-013 SHALL have port: tx2_busy  in  1  UART 2 shifting.
REQ-014 SHALL have port: busy  out  1  packet in progress.
REQ-015 SHALL have port: packet_sent  out  1  one-cycle pulse after the last byte is started.
REQ-016 SHALL have port: send_reject  out  1  one-cycle pulse when a send request is refused.

Function
REQ-017 SHALL contain a 256x8 payload buffer; wr_en writes wr_data at wr_addr on the clock edge, in any state; reads are synchronous, one cycle latency.
REQ-018 SHALL frame each packet as: 0xD5, len, payload[0..len-1] (buffer addresses 0..len-1), crc.
REQ-019 SHALL compute crc as CRC-8/Maxim (reflected polynomial 0x8C, init 0x00, no final XOR) over the payload bytes only, in transmit order.
REQ-020 SHALL use FSM states S_IDLE, S_SYNC, S_LEN, S_DATA, S_CRC; any other encoding returns to S_IDLE next cycle.
REQ-021 In S_IDLE, send with 1<=send_len<=255 SHALL latch send_len and send_dst, clear crc and read address, assert busy next cycle, and enter S_SYNC.
REQ-022 In S_IDLE, send with send_len==0 SHALL pulse send_reject the next cycle and remain in S_IDLE.
REQ-023 send while busy SHALL be ignored (no reject pulse, no effect on the transfer).
REQ-024 Selected port = latched dst; only that port's start and busy are used; the other start stays 0.
REQ-025 A byte SHALL be issued only when selected busy==0 and the guard flag is clear: tx_data takes the byte and selected start pulses high for exactly one cycle in the same cycle.
REQ-026 A guard flag SHALL be set for the one cycle after each start pulse, so no byte issues in that cycle, regardless of busy.
REQ-027 S_SYNC issues 0xD5 -> S_LEN; S_LEN issues len -> S_DATA.
REQ-028 S_DATA issues the buffer byte at the current read address, folds it into crc, and increments the address; after byte len-1 -> S_CRC.
REQ-029 The buffer read address SHALL be applied early enough that registered read data is valid when issued; the guard cycle covers the read latency.
REQ-030 S_CRC issues crc, pulses packet_sent the next cycle, deasserts busy the same cycle, and returns to S_IDLE.
REQ-031 tx_data SHALL hold its last value between issues.
REQ-032 Buffer writes during a transfer SHALL take effect immediately and may alter unsent bytes; the block applies no protection against this.
REQ-033 Back-to-back: send SHALL be accepted in the first S_IDLE cycle after packet_sent.

Reset
REQ-034 rst SHALL force S_IDLE with busy=0, tx1_start=0, tx2_start=0, tx_data=0x00, packet_sent=0, send_reject=0, guard=0, crc=0x00.
REQ-035 rst mid-packet SHALL abort with no further start pulses and no packet_sent; buffer contents are not cleared.
REQ-036 rst SHALL take priority over send, wr_en excepted.

Verification
REQ-037 Load "123456789" (0x31..0x39) at addresses 0..8, send len=9 dst=0, busy model 0 -> tx1 starts with D5 09 31..39 A1; tx2_start never high; packet_sent once.
REQ-038 len=1, payload 0x00, dst=1, UART busy 10 cycles after each start -> tx2 gets D5 01 00 00; each start occurs only after busy drops.
REQ-039 send len=0 -> send_reject pulses once, busy stays 0, no start pulses.
REQ-040 Second send asserted mid-packet -> ignored; the packet completes unchanged, with no reject pulse.
REQ-041 rst asserted after the 3rd payload byte -> no further starts, busy=0 next cycle; a new send len=2 then yields D5 02 b0 b1 crc correctly.
REQ-042 len=255 with incrementing payload -> 258 bytes; address stops at 254 without wrap; crc matches the reference model.
